// File: rtl/pwm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : pwm_pkg                                                       |
// | Purpose  : Shared defaults, ramp FSM state type and the duty slew helper |
// |            for the switch-driven PWM duty conditioning stage.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pwm_pkg;

  localparam int SW_W_DEF  = 4;
  localparam int CBITS_DEF = 13;

  // Working width of duty_step; callers zero-extend into it and truncate back.
  localparam int DUTY_FN_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Next duty code one step toward tgt. Comparing before stepping means the
  // result never leaves the closed range between cur and tgt, so no wrap.
  function automatic logic [DUTY_FN_W-1:0] duty_step(
    input logic [DUTY_FN_W-1:0] cur,
    input logic [DUTY_FN_W-1:0] tgt
  );
    if (tgt > cur) begin
      return cur + DUTY_FN_W'(1);
    end else if (tgt < cur) begin
      return cur - DUTY_FN_W'(1);
    end else begin
      return cur;
    end
  endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/sw_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sw_debounce                                                   |
// | Purpose  : Two-flop synchroniser for the raw duty switches plus an       |
// |            optional stability filter producing the target duty code.     |
// | Macro    : PWM_DUTY_DEBOUNCE_EN - builds the stability filter.           |
// | Ports    : clk         in   clock, rising edge                           |
// |            rst_n       in   async active-low reset                       |
// |            sw_raw      in   raw switches, asynchronous to clk            |
// |            target_code out  filtered (or just synchronised) switch code  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sw_debounce #(
  parameter int SW_W      = 4,
  parameter int DB_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw_raw,
  output logic [SW_W-1:0] target_code
);

  logic [SW_W-1:0] r_sync1;
  logic [SW_W-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_DUTY_DEBOUNCE_EN
  localparam int                 c_CNT_W    = $clog2(DB_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DB_CYCLES - 1);
  // The edge that advances the counter to its maximum is the one that
  // loads, giving exactly DB_CYCLES stable cycles after the synchroniser.
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DB_CYCLES - 2);

  logic [SW_W-1:0]    r_prev;
  logic [c_CNT_W-1:0] r_cnt;
  logic [SW_W-1:0]    r_target;
  logic               w_stable;

  assign w_stable = (r_sync2 == r_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_cnt    <= '0;
      r_target <= '0;
    end else begin
      r_prev <= r_sync2;
      if (!w_stable) begin
        r_cnt <= '0;
      end else begin
        // Saturate rather than wrap so a long-held value stays accepted.
        if (r_cnt != c_CNT_MAX) begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
        if (r_cnt >= c_CNT_LOAD) begin
          r_target <= r_sync2;
        end
      end
    end
  end

  assign target_code = r_target;
`else
  // Filter disabled: the second synchroniser flop is the target register.
  assign target_code = r_sync2;
`endif

endmodule : sw_debounce
`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pwm_duty_ramp                                                 |
// | Purpose  : Conditions the 4-bit duty switches and slews the PWM duty     |
// |            code one step at a time toward them, changing it only on a    |
// |            PWM period boundary.                                          |
// | Macro    : PWM_DUTY_DEBOUNCE_EN - enables the switch stability filter.   |
// | Ports    : clk          in   clock, rising edge                          |
// |            rst_n        in   async active-low reset                      |
// |            sw_raw       in   raw duty switches (asynchronous)            |
// |            duty_code    out  registered duty code for the PWM stage      |
// |            target_code  out  filtered switch value being ramped toward   |
// |            period_cnt   out  free-running PWM period counter             |
// |            period_start out  high while period_cnt is all-ones           |
// |            ramp_busy    out  high while duty_code != target_code         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int SW_W         = SW_W_DEF,
  parameter int CBITS        = CBITS_DEF,
  parameter int DB_CYCLES    = 1024,
  parameter int STEP_PERIODS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [SW_W-1:0]  duty_code,
  output logic [SW_W-1:0]  target_code,
  output logic [CBITS-1:0] period_cnt,
  output logic             period_start,
  output logic             ramp_busy
);

  localparam int                 c_PER_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(STEP_PERIODS - 1);

  logic [SW_W-1:0]    w_target;
  logic [SW_W-1:0]    w_next;
  logic [CBITS-1:0]   r_period_cnt;
  logic [SW_W-1:0]    r_duty;
  logic [c_PER_W-1:0] r_per_cnt;
  ramp_state_t        r_state;

  sw_debounce #(
    .SW_W      (SW_W),
    .DB_CYCLES (DB_CYCLES)
  ) u_sw_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_raw      (sw_raw),
    .target_code (w_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + CBITS'(1);
    end
  end

  // Steps are taken on the edge leaving the all-ones count, so each new
  // code is in force for the whole of the following period.
  assign period_start = &r_period_cnt;

  assign w_next = SW_W'(duty_step(DUTY_FN_W'(r_duty), DUTY_FN_W'(w_target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_per_cnt <= '0;
      r_duty    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_per_cnt <= '0;
          if (w_target != r_duty) begin
            r_state <= RAMP;
          end
        end
        RAMP: begin
          if (period_start) begin
            if (r_per_cnt == c_PER_LAST) begin
              r_per_cnt <= '0;
              // Direction is re-evaluated here against the live target; a
              // target that moved back onto the duty yields a hold and exit.
              r_duty    <= w_next;
              if (w_next == w_target) begin
                r_state <= IDLE;
              end
            end else begin
              r_per_cnt <= r_per_cnt + c_PER_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign duty_code   = r_duty;
  assign target_code = w_target;
  assign period_cnt  = r_period_cnt;
  assign ramp_busy   = (r_duty != w_target);

endmodule : pwm_duty_ramp
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pwm_duty_ramp                                              |
// | Purpose  : Directed self-checking bench for pwm_duty_ramp with a 16-cycle |
// |            period. Instance u_dut steps every period, u_dut3 every three.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pwm_duty_ramp;

`ifdef PWM_DUTY_DEBOUNCE_EN
  localparam int c_LAT  = 6;
  localparam bit c_FILT = 1'b1;
`else
  localparam int c_LAT  = 2;
  localparam bit c_FILT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_raw;

  logic [3:0] duty1, tgt1, pc1;
  logic       ps1, busy1;
  logic [3:0] duty2, tgt2, pc2;
  logic       ps2, busy2;

  int n_checks = 0;
  int n_errors = 0;

  pwm_duty_ramp #(.SW_W(4), .CBITS(4), .DB_CYCLES(4), .STEP_PERIODS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .duty_code(duty1), .target_code(tgt1), .period_cnt(pc1),
    .period_start(ps1), .ramp_busy(busy1)
  );

  pwm_duty_ramp #(.SW_W(4), .CBITS(4), .DB_CYCLES(4), .STEP_PERIODS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .duty_code(duty2), .target_code(tgt2), .period_cnt(pc2),
    .period_start(ps2), .ramp_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    @(negedge clk);
    sw_raw = v;
  endtask

  // Advance to just after the next period wrap edge (period_cnt now 0).
  task automatic wait_wrap();
    int k;
    k = 0;
    while (ps1 !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    chk("wrap_found", 16'(k < 40), 16'd1);
    tick(1);
  endtask

  // Per-cycle rules: duty moves only into period_cnt==0 and by exactly one;
  // period_start never lasts two cycles.
  logic [3:0] p_d1, p_d2;
  logic       p_ps1;
  logic       p_rst;
  initial begin
    p_d1 = '0; p_d2 = '0; p_ps1 = 1'b0; p_rst = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    if (rst_n && p_rst) begin
      if (duty1 !== p_d1) begin
        n_checks++;
        assert (pc1 == 4'd0 && (duty1 == p_d1 + 1 || duty1 + 1 == p_d1)) else begin
          n_errors++;
          $error("FAIL step_rule1 observed=%0h->%0h at cnt %0d", p_d1, duty1, pc1);
        end
      end
      if (duty2 !== p_d2) begin
        n_checks++;
        assert (pc2 == 4'd0 && (duty2 == p_d2 + 1 || duty2 + 1 == p_d2)) else begin
          n_errors++;
          $error("FAIL step_rule3 observed=%0h->%0h at cnt %0d", p_d2, duty2, pc2);
        end
      end
      if (ps1) begin
        n_checks++;
        assert (!p_ps1) else begin
          n_errors++;
          $error("FAIL ps_width observed=two-cycle pulse expected=single");
        end
      end
    end
    p_d1  = duty1;
    p_d2  = duty2;
    p_ps1 = ps1;
    p_rst = rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int t1[4], t2[4];
  logic [3:0] v1[4], v2[4];
  int n1, n2;
  logic [3:0] q1, q2;

  initial begin
    // 1. reset and first period_start
    rst_n  = 1'b0;
    sw_raw = 4'h0;
    tick(3);
    chk("rst_duty", duty1, 0);
    chk("rst_target", tgt1, 0);
    chk("rst_cnt", pc1, 0);
    chk("rst_pstart", ps1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_duty3", duty2, 0);
    chk("rst_target3", tgt2, 0);
    chk("rst_cnt3", pc2, 0);
    chk("rst_pstart3", ps2, 0);
    chk("rst_busy3", busy2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(14);
    chk("ps_before", ps1, 0);
    chk("cnt_14", pc1, 14);
    tick(1);
    chk("ps_first", ps1, 1);
    chk("cnt_15", pc1, 15);
    tick(1);
    chk("ps_after", ps1, 0);
    chk("cnt_wrap", pc1, 0);

    // 2. ramp up 0 -> 3
    set_sw(4'h3);
    tick(c_LAT - 1);
    chk("tgt_early", tgt1, 0);
    tick(1);
    chk("tgt_loaded", tgt1, 3);
    chk("busy_on", busy1, 1);
    for (int k = 1; k <= 3; k++) begin
      wait_wrap();
      chk("up3_duty", duty1, 16'(k));
      chk("up3_cnt", pc1, 0);
    end
    chk("up3_busy", busy1, 0);

    // 3. up to F, hold at F, then down to 0 with no wrap
    set_sw(4'hF);
    tick(c_LAT);
    chk("tgt_F", tgt1, 16'hF);
    for (int k = 4; k <= 15; k++) begin
      wait_wrap();
      chk("upF_duty", duty1, 16'(k));
    end
    chk("upF_busy", busy1, 0);
    wait_wrap();
    chk("hold_F", duty1, 16'hF);
    set_sw(4'h0);
    tick(c_LAT);
    chk("tgt_0", tgt1, 0);
    for (int k = 14; k >= 0; k--) begin
      wait_wrap();
      chk("down_duty", duty1, 16'(k));
    end
    wait_wrap();
    chk("hold_0", duty1, 0);

    // 4. three-cycle glitch to 8
    set_sw(4'h8);
    tick(2);
    chk("glitch_tgt", tgt1, c_FILT ? 16'h0 : 16'h8);
    tick(1);
    @(negedge clk);
    sw_raw = 4'h0;
    tick(8);
    chk("glitch_tgt_end", tgt1, 0);
    wait_wrap();
    chk("glitch_duty", duty1, 0);
    chk("glitch_busy", busy1, 0);

    // 5. retarget 8 -> 2 at duty 5
    set_sw(4'h8);
    tick(c_LAT);
    for (int k = 1; k <= 5; k++) begin
      wait_wrap();
      chk("to8_duty", duty1, 16'(k));
    end
    set_sw(4'h2);
    tick(c_LAT);
    chk("retgt", tgt1, 2);
    for (int k = 4; k >= 2; k--) begin
      wait_wrap();
      chk("retgt_duty", duty1, 16'(k));
    end
    chk("retgt_busy", busy1, 0);

    // 6. asynchronous reset mid-period during a ramp
    set_sw(4'h9);
    tick(c_LAT);
    wait_wrap();
    wait_wrap();
    chk("pre_arst_duty", duty1, 4);
    tick(5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_duty", duty1, 0);
    chk("arst_target", tgt1, 0);
    chk("arst_cnt", pc1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_duty3", duty2, 0);
    sw_raw = 4'h3;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;

    // 6/7. post-reset ramp from 0; STEP_PERIODS=3 instance spaced by 48
    n1 = 0; n2 = 0;
    q1 = duty1; q2 = duty2;
    for (int e = 1; e <= 160; e++) begin
      tick(1);
      if (duty1 !== q1 && n1 < 4) begin t1[n1] = e; v1[n1] = duty1; n1++; end
      if (duty2 !== q2 && n2 < 4) begin t2[n2] = e; v2[n2] = duty2; n2++; end
      q1 = duty1;
      q2 = duty2;
    end
    chk("post_n1", 16'(n1), 3);
    chk("post_n3", 16'(n2), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < n1) begin
        chk("post_t1", 16'(t1[i]), 16'(16 * (i + 1)));
        chk("post_v1", v1[i], 16'(i + 1));
      end
      if (i < n2) begin
        chk("post_t3", 16'(t2[i]), 16'(48 * (i + 1)));
        chk("post_v3", v2[i], 16'(i + 1));
      end
    end
    if (n2 >= 2) chk("step3_gap", 16'(t2[1] - t2[0]), 48);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pwm_duty_ramp
`default_nettype wire
